// File: rtl/inst_buffer_if.sv
// Purpose : fetch/ID-side bundle of the instruction queue (write slots, read slots, flush).
// Latency : n/a (wires only).
// Backpress: full_o throttles fetch; rd_en_i/issue_i tell the queue how much ID consumed.
//   master : fetch + ID stage side (drives writes, flush, rd_en_i, issue_i)
//   slave  : inst_buffer side (drives full_o, read slots, count_o)
interface inst_buffer_if #(
    parameter int AW = 4
);
    logic          flush;
    logic          wr_en1_i;
    logic          wr_en2_i;
    logic [31:0]   wr_inst1_i;
    logic [31:0]   wr_inst2_i;
    logic [31:0]   wr_addr1_i;
    logic [31:0]   wr_addr2_i;
    logic          full_o;
    logic          rd_en_i;
    logic          issue_i;
    logic          inst1_valid_o;
    logic          inst2_valid_o;
    logic [31:0]   inst1_o;
    logic [31:0]   inst2_o;
    logic [31:0]   inst1_addr_o;
    logic [31:0]   inst2_addr_o;
    logic [AW:0]   count_o;

    modport master (
        output flush, wr_en1_i, wr_en2_i, wr_inst1_i, wr_inst2_i,
               wr_addr1_i, wr_addr2_i, rd_en_i, issue_i,
        input  full_o, inst1_valid_o, inst2_valid_o, inst1_o, inst2_o,
               inst1_addr_o, inst2_addr_o, count_o
    );

    modport slave (
        input  flush, wr_en1_i, wr_en2_i, wr_inst1_i, wr_inst2_i,
               wr_addr1_i, wr_addr2_i, rd_en_i, issue_i,
        output full_o, inst1_valid_o, inst2_valid_o, inst1_o, inst2_o,
               inst1_addr_o, inst2_addr_o, count_o
    );
endinterface

// File: rtl/inst_buffer.sv
// Purpose : 2-in/2-out circular instruction queue between fetch and the dual-issue ID stage.
// Latency : write visible on read ports 1 cycle later; retire moves head at the clock edge.
// Backpress: full_o (<2 free) stops fetch; writes while full are dropped; rd_en_i low stalls ID.
//   ports  : clk, rst (sync, active-high), bus (inst_buffer_if.slave)
module inst_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic           clk,
    input  logic           rst,
    inst_buffer_if.slave   bus
);
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } entry_t;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   FULL_THR = (AW+1)'(DEPTH - 2);

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   cnt;

    logic          full;
    logic          wr_go;
    logic          we2;
    logic [1:0]    w;
    logic [1:0]    q;
    logic [1:0]    r;
    entry_t        head0;
    entry_t        head1;

    assign full  = (cnt > FULL_THR);
    // A write into a full queue is a protocol error; it is dropped rather than overwriting live data.
    assign wr_go = bus.wr_en1_i && !full;
    // Slot 2 without slot 1 would break program order, so slot 2 only counts alongside slot 1.
    assign we2   = bus.wr_en1_i && bus.wr_en2_i;

    always_comb begin
        w = 2'd0;
        if (wr_go) begin
            w = we2 ? 2'd2 : 2'd1;
        end
        q = 2'd0;
        if (bus.rd_en_i) begin
            q = bus.issue_i ? 2'd2 : 2'd1;
        end
        // Clamp the retire to what is present; cnt < q only happens for cnt of 0 or 1.
        r = q;
        if ((AW+1)'(q) > cnt) begin
            r = cnt[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(r);
            wr_ptr <= wr_ptr + AW'(w);
            cnt    <= cnt + (AW+1)'(w) - (AW+1)'(r);
        end
    end

    // Array contents survive reset/flush; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && wr_go) begin
            mem[wr_ptr] <= '{inst: bus.wr_inst1_i, addr: bus.wr_addr1_i};
            if (we2) begin
                mem[wr_ptr + PTR_ONE] <= '{inst: bus.wr_inst2_i, addr: bus.wr_addr2_i};
            end
        end
    end

    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr + PTR_ONE];

    assign bus.full_o        = full;
    assign bus.count_o       = cnt;
    assign bus.inst1_valid_o = (cnt >= (AW+1)'(1));
    assign bus.inst2_valid_o = (cnt >= (AW+1)'(2));
    assign bus.inst1_o       = bus.inst1_valid_o ? head0.inst : 32'h0;
    assign bus.inst1_addr_o  = bus.inst1_valid_o ? head0.addr : 32'h0;
    assign bus.inst2_o       = bus.inst2_valid_o ? head1.inst : 32'h0;
    assign bus.inst2_addr_o  = bus.inst2_valid_o ? head1.addr : 32'h0;
endmodule

// File: tb/tb_inst_buffer.sv
// Purpose : self-checking bench for inst_buffer against a queue-based reference model.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpress: random stimulus only writes when the model says at least 2 entries are free.
module tb_inst_buffer;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_buffer_if #(.AW(AW)) bus ();

    inst_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t mq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Drive one cycle of stimulus, advance the reference queue at the edge, then settle.
    task automatic cyc(input bit e1, input bit e2,
                       input logic [31:0] i1, input logic [31:0] a1,
                       input logic [31:0] i2, input logic [31:0] a2,
                       input bit rd, input bit iss, input bit fl);
        int n;
        int qreq;
        bus.wr_en1_i   = e1;
        bus.wr_en2_i   = e2;
        bus.wr_inst1_i = i1;
        bus.wr_addr1_i = a1;
        bus.wr_inst2_i = i2;
        bus.wr_addr2_i = a2;
        bus.rd_en_i    = rd;
        bus.issue_i    = iss;
        bus.flush      = fl;
        @(posedge clk);
        if (rst || fl) begin
            mq.delete();
        end else begin
            n    = mq.size();
            qreq = rd ? (iss ? 2 : 1) : 0;
            if (e1 && n > DEPTH - 2) begin
                vectors++;
                miscompares++;
                $display("FAIL protocol: write issued with %0d entries, required at most %0d", n, DEPTH - 2);
            end
            for (int k = 0; k < qreq && mq.size() > 0; k++) void'(mq.pop_front());
            if (e1 && n <= DEPTH - 2) begin
                mq.push_back('{inst: i1, addr: a1});
                if (e2) mq.push_back('{inst: i2, addr: a2});
            end
        end
        #1;
        bus.wr_en1_i = 1'b0;
        bus.wr_en2_i = 1'b0;
        bus.rd_en_i  = 1'b0;
        bus.issue_i  = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic idle();
        cyc(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        vectors++;
        if (bus.count_o !== 5'd0 || bus.full_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cnt: count=%0d full=%b, required 0/0", bus.count_o, bus.full_o);
        end
        vectors++;
        if ({bus.inst1_valid_o, bus.inst2_valid_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_valid: got %b%b, required 00", bus.inst1_valid_o, bus.inst2_valid_o);
        end
        vectors++;
        if ({bus.inst1_o, bus.inst1_addr_o, bus.inst2_o, bus.inst2_addr_o} !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h %h %h %h, required all 0",
                     bus.inst1_o, bus.inst1_addr_o, bus.inst2_o, bus.inst2_addr_o);
        end
        cyc(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1, 0);
        vectors++;
        if (bus.count_o !== 5'd0) begin
            miscompares++;
            $display("FAIL empty_read: count=%0d, required 0", bus.count_o);
        end
    endtask

    task automatic test_dual_write_read();
        cyc(1, 1, 32'h24010001, 32'hBFC00000, 32'h24020002, 32'hBFC00004, 0, 0, 0);
        vectors++;
        if ({bus.inst1_valid_o, bus.inst2_valid_o} !== 2'b11) begin
            miscompares++;
            $display("FAIL dual_valid: got %b%b, required 11", bus.inst1_valid_o, bus.inst2_valid_o);
        end
        vectors++;
        if (bus.inst1_o !== 32'h24010001 || bus.inst1_addr_o !== 32'hBFC00000) begin
            miscompares++;
            $display("FAIL dual_slot1: got %h@%h, required 24010001@bfc00000", bus.inst1_o, bus.inst1_addr_o);
        end
        vectors++;
        if (bus.inst2_o !== 32'h24020002 || bus.inst2_addr_o !== 32'hBFC00004) begin
            miscompares++;
            $display("FAIL dual_slot2: got %h@%h, required 24020002@bfc00004", bus.inst2_o, bus.inst2_addr_o);
        end
        cyc(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1, 0);
        vectors++;
        if (bus.count_o !== 5'd0 || {bus.inst1_valid_o, bus.inst2_valid_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL dual_retire: count=%0d valids=%b%b, required 0/00",
                     bus.count_o, bus.inst1_valid_o, bus.inst2_valid_o);
        end
    endtask

    task automatic test_single_drain();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h100;
        exp_pc[1] = 32'h104;
        exp_pc[2] = 32'h108;
        cyc(1, 1, 32'hA0, 32'h100, 32'hA1, 32'h104, 0, 0, 0);
        cyc(1, 0, 32'hA2, 32'h108, 32'h0, 32'h0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (bus.inst1_addr_o !== exp_pc[k] || bus.count_o !== 5'(3 - k)) begin
                miscompares++;
                $display("FAIL drain_head%0d: pc=%h count=%0d, required %h/%0d",
                         k, bus.inst1_addr_o, bus.count_o, exp_pc[k], 3 - k);
            end
            vectors++;
            if (bus.inst2_valid_o !== (k < 2)) begin
                miscompares++;
                $display("FAIL drain_v2_%0d: got %b, required %b", k, bus.inst2_valid_o, (k < 2));
            end
            // Last entry is retired by a dual request, which must clamp to one.
            cyc(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, (k == 2), 0);
        end
        vectors++;
        if (bus.count_o !== 5'd0 || bus.inst1_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_last: count=%0d v1=%b, required 0/0", bus.count_o, bus.inst1_valid_o);
        end
    endtask

    task automatic test_fill_full();
        for (int k = 1; k <= DEPTH / 2; k++) begin
            cyc(1, 1, $urandom, 32'h1000 + 32'(8 * k), $urandom, 32'h1004 + 32'(8 * k), 0, 0, 0);
            vectors++;
            if (bus.count_o !== 5'(2 * k) || bus.full_o !== (2 * k > DEPTH - 2)) begin
                miscompares++;
                $display("FAIL fill_%0d: count=%0d full=%b, required %0d/%b",
                         k, bus.count_o, bus.full_o, 2 * k, (2 * k > DEPTH - 2));
            end
        end
        cyc(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1, 0);
        vectors++;
        if (bus.count_o !== 5'(DEPTH - 2) || bus.full_o !== 1'b0) begin
            miscompares++;
            $display("FAIL unfull: count=%0d full=%b, required %0d/0", bus.count_o, bus.full_o, DEPTH - 2);
        end
        vectors++;
        if (bus.inst1_addr_o !== mq[0].addr || bus.inst2_addr_o !== mq[1].addr) begin
            miscompares++;
            $display("FAIL unfull_head: got %h/%h, required %h/%h",
                     bus.inst1_addr_o, bus.inst2_addr_o, mq[0].addr, mq[1].addr);
        end
        while (mq.size() > 0) cyc(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1, 0);
    endtask

    task automatic test_wrap();
        cyc(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1);
        // One-in/one-out walks both pointers forward: rd ends at DEPTH-2, wr at DEPTH-1.
        for (int k = 0; k < DEPTH - 1; k++) cyc(1, 0, 32'hDEAD0000 + 32'(k), 32'h0, 32'h0, 32'h0, 1, 0, 0);
        cyc(1, 1, 32'hC200, 32'h200, 32'hC204, 32'h204, 1, 0, 0);
        vectors++;
        if (bus.inst1_addr_o !== 32'h200 || bus.inst2_addr_o !== 32'h204 || bus.count_o !== 5'd2) begin
            miscompares++;
            $display("FAIL wrap_read: got %h/%h count=%0d, required 200/204/2",
                     bus.inst1_addr_o, bus.inst2_addr_o, bus.count_o);
        end
        cyc(1, 1, 32'hC208, 32'h208, 32'hC20C, 32'h20C, 1, 1, 0);
        vectors++;
        if (bus.inst1_o !== 32'hC208 || bus.inst2_o !== 32'hC20C || bus.count_o !== 5'd2) begin
            miscompares++;
            $display("FAIL wrap_write: got %h/%h count=%0d, required c208/c20c/2",
                     bus.inst1_o, bus.inst2_o, bus.count_o);
        end
        cyc(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1, 0);
    endtask

    task automatic test_flush();
        cyc(1, 1, 32'h1, 32'h10, 32'h2, 32'h14, 0, 0, 0);
        cyc(1, 1, 32'h3, 32'h18, 32'h4, 32'h1C, 0, 0, 0);
        cyc(1, 0, 32'h5, 32'h20, 32'h0, 32'h0, 0, 0, 0);
        vectors++;
        if (bus.count_o !== 5'd5) begin
            miscompares++;
            $display("FAIL flush_pre: count=%0d, required 5", bus.count_o);
        end
        cyc(1, 1, 32'h6, 32'h24, 32'h7, 32'h28, 1, 1, 1);
        vectors++;
        if (bus.count_o !== 5'd0 || {bus.inst1_valid_o, bus.inst2_valid_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_clear: count=%0d valids=%b%b, required 0/00",
                     bus.count_o, bus.inst1_valid_o, bus.inst2_valid_o);
        end
        cyc(1, 0, 32'h8C000300, 32'h300, 32'h0, 32'h0, 0, 0, 0);
        vectors++;
        if (bus.inst1_o !== 32'h8C000300 || bus.inst1_addr_o !== 32'h300 || bus.count_o !== 5'd1) begin
            miscompares++;
            $display("FAIL flush_after: got %h@%h count=%0d, required 8c000300@300/1",
                     bus.inst1_o, bus.inst1_addr_o, bus.count_o);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bit e1;
            bit e2;
            ent_t x0;
            ent_t x1;
            int n;
            e1 = (mq.size() <= DEPTH - 2) && ($urandom_range(0, 3) != 0);
            e2 = e1 && $urandom_range(0, 1);
            cyc(e1, e2, $urandom, $urandom, $urandom, $urandom,
                ($urandom_range(0, 2) != 0), $urandom_range(0, 1), ($urandom_range(0, 40) == 0));
            n  = mq.size();
            x0 = (n >= 1) ? mq[0] : '0;
            x1 = (n >= 2) ? mq[1] : '0;
            vectors++;
            if (bus.count_o !== 5'(n) || bus.full_o !== (n > DEPTH - 2)) begin
                miscompares++;
                $display("FAIL rnd_cnt@%0d: count=%0d full=%b, required %0d/%b",
                         c, bus.count_o, bus.full_o, n, (n > DEPTH - 2));
            end
            vectors++;
            if (bus.inst1_valid_o !== (n >= 1) || bus.inst2_valid_o !== (n >= 2)) begin
                miscompares++;
                $display("FAIL rnd_valid@%0d: got %b%b, required %b%b",
                         c, bus.inst1_valid_o, bus.inst2_valid_o, (n >= 1), (n >= 2));
            end
            vectors++;
            if ({bus.inst1_o, bus.inst1_addr_o} !== {x0.inst, x0.addr}) begin
                miscompares++;
                $display("FAIL rnd_slot1@%0d: got %h@%h, required %h@%h",
                         c, bus.inst1_o, bus.inst1_addr_o, x0.inst, x0.addr);
            end
            vectors++;
            if ({bus.inst2_o, bus.inst2_addr_o} !== {x1.inst, x1.addr}) begin
                miscompares++;
                $display("FAIL rnd_slot2@%0d: got %h@%h, required %h@%h",
                         c, bus.inst2_o, bus.inst2_addr_o, x1.inst, x1.addr);
            end
        end
    endtask

    initial begin
        bus.flush      = 1'b0;
        bus.wr_en1_i   = 1'b0;
        bus.wr_en2_i   = 1'b0;
        bus.wr_inst1_i = 32'h0;
        bus.wr_inst2_i = 32'h0;
        bus.wr_addr1_i = 32'h0;
        bus.wr_addr2_i = 32'h0;
        bus.rd_en_i    = 1'b0;
        bus.issue_i    = 1'b0;
        test_reset();
        test_dual_write_read();
        test_single_drain();
        test_fill_full();
        test_wrap();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
